eth_rgmii_rx_framer: RTL and testbench



---
 rtl/eth_rgmii_rx_framer_pkg.sv | 17 +
 rtl/eth_rgmii_rx_framer_if.sv | 26 ++
 rtl/eth_rx_word_pack.sv | 88 ++++++++
 rtl/eth_rgmii_rx_framer.sv | 146 ++++++++++++++
 tb/tb_eth_rgmii_rx_framer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_rgmii_rx_framer_pkg.sv
// Shared types and constants for the RGMII receive framer.
// Preamble/SFD patterns are given in both byte (gigabit) and nibble (10/100) form.
package eth_rgmii_pkg;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_IDLE,
    ST_PRE,
    ST_DATA
  } rx_state_e;

  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam logic [3:0] PRE_NIB  = 4'h5;
  localparam logic [3:0] SFD_NIB  = 4'hD;

endpackage

// File: rtl/eth_rgmii_rx_framer_if.sv
// RGMII receive halves in, packed payload words out.
// The framer connects through the master modport; the PHY/MAC side uses slave.
interface eth_rgmii_rx_framer_if #(
  parameter int unsigned BYTES = 1
);
  logic                 i_rx_ctl_h;
  logic                 i_rx_ctl_l;
  logic [3:0]           i_rx_data_h;
  logic [3:0]           i_rx_data_l;
  logic                 o_valid;
  logic [8*BYTES-1:0]   o_data;
  logic [BYTES-1:0]     o_be;
  logic                 o_sof;
  logic                 o_eof;
  logic                 o_err;

  modport master (
    input  i_rx_ctl_h, i_rx_ctl_l, i_rx_data_h, i_rx_data_l,
    output o_valid, o_data, o_be, o_sof, o_eof, o_err
  );

  modport slave (
    output i_rx_ctl_h, i_rx_ctl_l, i_rx_data_h, i_rx_data_l,
    input  o_valid, o_data, o_be, o_sof, o_eof, o_err
  );
endinterface

// File: rtl/eth_rx_word_pack.sv
// Packs received bytes into BYTES-wide words. A full word is held until the
// next byte arrives (mid-frame word) or the frame is flushed (EOF word).
module eth_rx_word_pack #(
  parameter int unsigned BYTES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_byte_vld,
  input  logic [7:0]         i_byte,
  input  logic               i_flush,
  input  logic               i_flush_err,
  output logic               o_valid,
  output logic [8*BYTES-1:0] o_data,
  output logic [BYTES-1:0]   o_be,
  output logic               o_sof,
  output logic               o_eof,
  output logic               o_err
);
  localparam int unsigned CW = $clog2(BYTES + 1);

  logic [CW-1:0]      r_cnt;
  logic [8*BYTES-1:0] r_acc;
  logic               r_first;
  logic [BYTES-1:0]   w_be;
  logic [8*BYTES-1:0] w_acc_ins;
  logic               w_full;

  assign w_full = (r_cnt == CW'(BYTES));

  always_comb begin
    w_be      = '0;
    w_acc_ins = r_acc;
    for (int unsigned i = 0; i < BYTES; i++) begin
      w_be[i] = (CW'(i) < r_cnt);
      if (CW'(i) == r_cnt) w_acc_ins[8*i +: 8] = i_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_first <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_be    <= '0;
      o_sof   <= 1'b0;
      o_eof   <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_sof   <= 1'b0;
      o_eof   <= 1'b0;
      o_err   <= 1'b0;
      if (i_start) begin
        r_cnt   <= '0;
        r_acc   <= '0;
        r_first <= 1'b1;
      end else if (i_flush) begin
        // An empty first word still strobes so SFD-only frames are visible.
        o_valid <= 1'b1;
        o_data  <= r_acc;
        o_be    <= w_be;
        o_sof   <= r_first;
        o_eof   <= 1'b1;
        o_err   <= i_flush_err;
        r_cnt   <= '0;
        r_acc   <= '0;
        r_first <= 1'b0;
      end else if (i_byte_vld) begin
        if (w_full) begin
          o_valid <= 1'b1;
          o_data  <= r_acc;
          o_be    <= w_be;
          o_sof   <= r_first;
          r_first <= 1'b0;
          r_acc   <= (8*BYTES)'(i_byte);
          r_cnt   <= CW'(1);
        end else begin
          r_acc <= w_acc_ins;
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/eth_rgmii_rx_framer.sv
// RGMII receive framer: preamble/SFD lock, MII nibble assembly, RX_ER decode,
// word packing and saturating frame/error counters.
module eth_rgmii_rx_framer #(
  parameter int unsigned BYTES = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_mii,
  eth_rgmii_rx_framer_if.master  bus,
  output logic [CNT_W-1:0]       o_frame_cnt,
  output logic [CNT_W-1:0]       o_err_cnt
);
  import eth_rgmii_pkg::*;

  rx_state_e  r_state, w_next;
  logic       r_armed;
  logic       r_ctl_h, r_ctl_l;
  logic [3:0] r_dat_h, r_dat_l;
  logic       r_mii, r_seen5, r_phase, r_ferr;
  logic [3:0] r_nib_lo;
  logic [CNT_W-1:0] r_frame_cnt, r_err_cnt;

  logic       w_dv, w_er;
  logic [7:0] w_byte_in, w_byte;
  logic       w_start, w_byte_vld, w_flush, w_flush_err, w_pre_bad;

  assign w_dv      = r_ctl_h;
  assign w_er      = r_ctl_h & ~r_ctl_l;
  assign w_byte_in = {r_dat_l, r_dat_h};

  // r_armed keeps HUNT from treating the reset value of r_ctl_h as a real DV-low sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_armed <= 1'b0;
      r_ctl_h <= 1'b0;
      r_ctl_l <= 1'b0;
      r_dat_h <= '0;
      r_dat_l <= '0;
    end else begin
      r_armed <= 1'b1;
      r_ctl_h <= bus.i_rx_ctl_h;
      r_ctl_l <= bus.i_rx_ctl_l;
      r_dat_h <= bus.i_rx_data_h;
      r_dat_l <= bus.i_rx_data_l;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_byte_vld  = 1'b0;
    w_byte      = w_byte_in;
    w_flush     = 1'b0;
    w_flush_err = 1'b0;
    w_pre_bad   = 1'b0;
    unique case (r_state)
      ST_HUNT: if (r_armed && !w_dv) w_next = ST_IDLE;
      ST_IDLE: if (w_dv) w_next = ST_PRE;
      ST_PRE: begin
        if (!w_dv) begin
          w_next = ST_IDLE;
        end else if (r_mii) begin
          if (r_dat_h == SFD_NIB && r_seen5) begin
            w_next  = ST_DATA;
            w_start = 1'b1;
          end else if (r_dat_h != PRE_NIB) begin
            w_next    = ST_HUNT;
            w_pre_bad = 1'b1;
          end
        end else begin
          if (w_byte_in == SFD_BYTE) begin
            w_next  = ST_DATA;
            w_start = 1'b1;
          end else if (w_byte_in != PRE_BYTE) begin
            w_next    = ST_HUNT;
            w_pre_bad = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (!w_dv) begin
          w_next      = ST_IDLE;
          w_flush     = 1'b1;
          w_flush_err = r_ferr | (r_mii & r_phase);
        end else if (!r_mii || r_phase) begin
          w_byte_vld = 1'b1;
          w_byte     = r_mii ? {r_dat_h, r_nib_lo} : w_byte_in;
        end
      end
      default: w_next = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_HUNT;
      r_mii       <= 1'b0;
      r_seen5     <= 1'b0;
      r_phase     <= 1'b0;
      r_nib_lo    <= '0;
      r_ferr      <= 1'b0;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE) begin
        r_mii   <= i_mii;
        r_seen5 <= 1'b0;
      end else if (r_state == ST_PRE && r_mii && w_dv && r_dat_h == PRE_NIB) begin
        r_seen5 <= 1'b1;
      end
      if (w_start) begin
        r_phase <= 1'b0;
        r_ferr  <= 1'b0;
      end else if (r_state == ST_DATA && w_dv) begin
        if (r_mii) r_phase <= ~r_phase;
        if (r_mii && !r_phase) r_nib_lo <= r_dat_h;
        if (w_er) r_ferr <= 1'b1;
      end
      if (w_flush && r_frame_cnt != '1) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      if ((w_pre_bad || (w_flush && w_flush_err)) && r_err_cnt != '1)
        r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign o_frame_cnt = r_frame_cnt;
  assign o_err_cnt   = r_err_cnt;

  eth_rx_word_pack #(.BYTES(BYTES)) u_pack (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_start),
    .i_byte_vld  (w_byte_vld),
    .i_byte      (w_byte),
    .i_flush     (w_flush),
    .i_flush_err (w_flush_err),
    .o_valid     (bus.o_valid),
    .o_data      (bus.o_data),
    .o_be        (bus.o_be),
    .o_sof       (bus.o_sof),
    .o_eof       (bus.o_eof),
    .o_err       (bus.o_err)
  );

endmodule

// File: tb/tb_eth_rgmii_rx_framer.sv
// Scoreboard bench: a gigabit BYTES=4 instance (3-bit counters) and an MII BYTES=2 instance.
// Stimulus pushes expected words; per-instance monitors pop and compare on every strobe.
module tb_eth_rgmii_rx_framer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mii_a = 1'b0;
  logic mii_b = 1'b1;
  logic [2:0]  fc_a, ec_a;
  logic [15:0] fc_b, ec_b;

  eth_rgmii_rx_framer_if #(.BYTES(4)) ifa ();
  eth_rgmii_rx_framer_if #(.BYTES(2)) ifb ();

  eth_rgmii_rx_framer #(.BYTES(4), .CNT_W(3)) dut_a (
    .clk(clk), .rst(rst), .i_mii(mii_a), .bus(ifa),
    .o_frame_cnt(fc_a), .o_err_cnt(ec_a)
  );

  eth_rgmii_rx_framer #(.BYTES(2), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .i_mii(mii_b), .bus(ifb),
    .o_frame_cnt(fc_b), .o_err_cnt(ec_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  be;
    logic        sof;
    logic        eof;
    logic        err;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int vectors = 0;
  int miscompares = 0;
  logic [2:0] exp_fc_a = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_a(input logic [31:0] d, input logic [3:0] be, input logic s, input logic e, input logic r);
    exp_t x;
    x.data = d; x.be = be; x.sof = s; x.eof = e; x.err = r;
    q_a.push_back(x);
  endtask

  task automatic push_b(input logic [31:0] d, input logic [3:0] be, input logic s, input logic e, input logic r);
    exp_t x;
    x.data = d; x.be = be; x.sof = s; x.eof = e; x.err = r;
    q_b.push_back(x);
  endtask

  always @(negedge clk) begin
    if (!rst && ifa.o_valid) begin
      if (q_a.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL a_unexpected: got strobe data 0x%0h, want no strobe", ifa.o_data);
      end else begin
        ea = q_a.pop_front();
        check("a_data", ifa.o_data, ea.data);
        check("a_be", {28'b0, ifa.o_be}, {28'b0, ea.be});
        check("a_flags", {29'b0, ifa.o_sof, ifa.o_eof, ifa.o_eof & ifa.o_err},
              {29'b0, ea.sof, ea.eof, ea.err});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ifb.o_valid) begin
      if (q_b.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL b_unexpected: got strobe data 0x%0h, want no strobe", ifb.o_data);
      end else begin
        eb = q_b.pop_front();
        check("b_data", {16'b0, ifb.o_data}, eb.data);
        check("b_be", {30'b0, ifb.o_be}, eb.be);
        check("b_flags", {29'b0, ifb.o_sof, ifb.o_eof, ifb.o_eof & ifb.o_err},
              {29'b0, eb.sof, eb.eof, eb.err});
      end
    end
  end

  task automatic g_byte(input logic [7:0] b, input logic er = 1'b0);
    @(negedge clk);
    ifa.i_rx_ctl_h  = 1'b1;
    ifa.i_rx_ctl_l  = ~er;
    ifa.i_rx_data_h = b[3:0];
    ifa.i_rx_data_l = b[7:4];
  endtask

  task automatic g_idle(input int n, input logic ext = 1'b0);
    repeat (n) begin
      @(negedge clk);
      ifa.i_rx_ctl_h  = 1'b0;
      ifa.i_rx_ctl_l  = ext;
      ifa.i_rx_data_h = ext ? 4'hF : 4'h0;
      ifa.i_rx_data_l = ext ? 4'hF : 4'h0;
    end
  endtask

  task automatic g_pre(input int n);
    repeat (n) g_byte(8'h55);
    g_byte(8'hD5);
  endtask

  task automatic m_nib(input logic [3:0] n);
    @(negedge clk);
    ifb.i_rx_ctl_h  = 1'b1;
    ifb.i_rx_ctl_l  = 1'b1;
    ifb.i_rx_data_h = n;
    ifb.i_rx_data_l = 4'hF;
  endtask

  task automatic m_byte(input logic [7:0] b);
    m_nib(b[3:0]);
    m_nib(b[7:4]);
  endtask

  task automatic m_idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ifb.i_rx_ctl_h  = 1'b0;
      ifb.i_rx_ctl_l  = 1'b0;
      ifb.i_rx_data_h = 4'h0;
      ifb.i_rx_data_l = 4'h0;
    end
  endtask

  task automatic m_pre();
    repeat (14) m_nib(4'h5);
    m_nib(4'hD);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no end of stimulus, want completion");
    $fatal(1);
  end

  initial begin
    ifa.i_rx_ctl_h = 1'b0; ifa.i_rx_ctl_l = 1'b0; ifa.i_rx_data_h = '0; ifa.i_rx_data_l = '0;
    ifb.i_rx_ctl_h = 1'b0; ifb.i_rx_ctl_l = 1'b0; ifb.i_rx_data_h = '0; ifb.i_rx_data_l = '0;

    // Frame in progress across reset release must never be accepted.
    repeat (3) g_byte(8'h55);
    check("rst_valid_a", {31'b0, ifa.o_valid}, 32'd0);
    check("rst_valid_b", {31'b0, ifb.o_valid}, 32'd0);
    check("rst_fc_a", {29'b0, fc_a}, 32'd0);
    check("rst_ec_a", {29'b0, ec_a}, 32'd0);
    check("rst_fc_b", {16'b0, fc_b}, 32'd0);
    check("rst_ec_b", {16'b0, ec_b}, 32'd0);
    rst = 1'b0;
    g_byte(8'h55); g_byte(8'h55); g_byte(8'hD5);
    repeat (4) g_byte(8'h99);
    g_idle(4);
    check("hunt_fc_a", {29'b0, fc_a}, 32'd0);
    check("hunt_ec_a", {29'b0, ec_a}, 32'd0);

    // Gigabit 10-byte frame
    push_a(32'h04030201, 4'b1111, 1, 0, 0);
    push_a(32'h08070605, 4'b1111, 0, 0, 0);
    push_a(32'h00000A09, 4'b0011, 0, 1, 0);
    g_pre(7);
    for (int i = 1; i <= 10; i++) g_byte(8'(i));
    g_idle(4);
    exp_fc_a = 3'd1;
    check("f1_fc_a", {29'b0, fc_a}, {29'b0, exp_fc_a});
    check("f1_ec_a", {29'b0, ec_a}, 32'd0);

    // RX_ER on payload byte 5
    push_a(32'h04030201, 4'b1111, 1, 0, 0);
    push_a(32'h08070605, 4'b1111, 0, 1, 1);
    g_pre(7);
    for (int i = 1; i <= 8; i++) g_byte(8'(i), i == 5);
    g_idle(4);
    exp_fc_a = 3'd2;
    check("er_fc_a", {29'b0, fc_a}, {29'b0, exp_fc_a});
    check("er_ec_a", {29'b0, ec_a}, 32'd1);

    g_idle(3, 1'b1);
    g_idle(2);

    // Bad preamble byte
    g_byte(8'h55); g_byte(8'h55); g_byte(8'h55); g_byte(8'h57);
    g_byte(8'h55); g_byte(8'hD5); g_byte(8'h11); g_byte(8'h22);
    g_idle(4);
    check("bad_fc_a", {29'b0, fc_a}, {29'b0, exp_fc_a});
    check("bad_ec_a", {29'b0, ec_a}, 32'd2);

    // SFD immediately followed by DV low
    push_a(32'h0, 4'b0000, 1, 1, 0);
    g_pre(7);
    g_idle(4);
    exp_fc_a = 3'd3;
    check("sfd_fc_a", {29'b0, fc_a}, {29'b0, exp_fc_a});

    // One-byte frames until the 3-bit frame counter saturates
    for (int k = 0; k < 5; k++) begin
      push_a(32'h40 + 32'(k), 4'b0001, 1, 1, 0);
      g_pre(2);
      g_byte(8'h40 + 8'(k));
      g_idle(4);
      if (exp_fc_a != 3'd7) exp_fc_a = exp_fc_a + 3'd1;
      check("sat_fc_a", {29'b0, fc_a}, {29'b0, exp_fc_a});
    end
    check("sat_ec_a", {29'b0, ec_a}, 32'd2);

    // MII two-byte frame
    push_b(32'h3CA5, 4'b0011, 1, 1, 0);
    m_idle(2);
    m_pre();
    m_byte(8'hA5); m_byte(8'h3C);
    m_idle(4);
    check("m1_fc_b", {16'b0, fc_b}, 32'd1);
    check("m1_ec_b", {16'b0, ec_b}, 32'd0);

    // MII odd nibble count
    push_b(32'h0021, 4'b0001, 1, 1, 1);
    m_pre();
    m_nib(4'h1); m_nib(4'h2); m_nib(4'h3);
    m_idle(4);
    check("odd_fc_b", {16'b0, fc_b}, 32'd2);
    check("odd_ec_b", {16'b0, ec_b}, 32'd1);

    // MII five-byte frame
    push_b(32'h2211, 4'b0011, 1, 0, 0);
    push_b(32'h4433, 4'b0011, 0, 0, 0);
    push_b(32'h0055, 4'b0001, 0, 1, 0);
    m_pre();
    m_byte(8'h11); m_byte(8'h22); m_byte(8'h33); m_byte(8'h44); m_byte(8'h55);
    m_idle(4);
    check("m5_fc_b", {16'b0, fc_b}, 32'd3);
    check("m5_ec_b", {16'b0, ec_b}, 32'd1);

    repeat (10) @(negedge clk);
    check("a_drain", q_a.size(), 32'd0);
    check("b_drain", q_b.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
